// File: rtl/aib_calib_pkg.sv
// Shared state encoding and CSR programming table for the AIB slave calibration FSM.
package aib_calib_pkg;

    localparam int unsigned AVMM_WIDTH    = 32;
    localparam int unsigned BYTE_WIDTH    = 4;
    localparam int unsigned ADDR_WIDTH    = 17;
    localparam int unsigned CFG_TABLE_LEN = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RESET_HOLD,
        ST_CFG_WRITE,
        ST_CFG_DONE,
        ST_ASSERT_READY,
        ST_SEND_DLL_LOCK_REQ,
        ST_WAIT_TRANSFER_EN,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CFG_ADDR [CFG_TABLE_LEN] = '{
        17'h00208, 17'h00210, 17'h00218, 17'h00320
    };

    localparam logic [AVMM_WIDTH-1:0] CFG_DATA [CFG_TABLE_LEN] = '{
        32'h0600_0000, 32'h0000_0003, 32'h8000_0000, 32'h0000_1C00
    };

endpackage

// File: rtl/aib_avmm_cfg_writer.sv
// Walks the package CSR table as back-to-back Avalon-MM writes, honouring waitrequest.
module aib_avmm_cfg_writer
    import aib_calib_pkg::*;
#(
    parameter int unsigned NUM_WORDS = CFG_TABLE_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] avmm_address_o,
    output logic                  avmm_write_o,
    output logic [AVMM_WIDTH-1:0] avmm_writedata_o,
    output logic [BYTE_WIDTH-1:0] avmm_byteenable_o,
    input  logic                  avmm_waitrequest_i
);

    localparam int unsigned     IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic                  write_q, write_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AVMM_WIDTH-1:0] data_q, data_d;
    logic                  accept;
    logic                  last;

    assign accept = write_q && !avmm_waitrequest_i;
    assign last   = (idx_q == LAST_IDX);

    // abort only takes effect on an accepted beat, so a stalled write is never withdrawn
    always_comb begin
        write_d = write_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (start_i) begin
            write_d = 1'b1;
            idx_d   = '0;
            addr_d  = CFG_ADDR[0];
            data_d  = CFG_DATA[0];
        end else if (accept) begin
            if (last || abort_i) begin
                write_d = 1'b0;
            end else begin
                idx_d  = idx_q + 1'b1;
                addr_d = CFG_ADDR[idx_d];
                data_d = CFG_DATA[idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            write_q <= write_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign done_o            = accept && last;
    assign busy_o            = write_q;
    assign avmm_write_o      = write_q;
    assign avmm_address_o    = addr_q;
    assign avmm_writedata_o  = data_q;
    assign avmm_byteenable_o = {BYTE_WIDTH{write_q}};

endmodule

// File: rtl/aib_calib_slave_fsm.sv
// Slave-side AIB calibration sequencer: adapter reset, CSR programming, ready/lock
// handshake, transfer-enable wait with timeout/retry and link-drop recovery.
module aib_calib_slave_fsm
    import aib_calib_pkg::*;
#(
    parameter int unsigned TOTAL_CHNL_NUM = 24,
    parameter int unsigned RST_HOLD_CYC   = 16,
    parameter int unsigned TIMEOUT_CYC    = 4096,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned NUM_CFG_WORDS  = CFG_TABLE_LEN
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             calib_restart,
    input  logic [TOTAL_CHNL_NUM-1:0]        ms_tx_transfer_en,
    input  logic [TOTAL_CHNL_NUM-1:0]        ms_rx_transfer_en,
    output logic                             calib_done,
    output logic                             calib_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_count,
    output logic                             i_conf_done,
    output logic [TOTAL_CHNL_NUM-1:0]        ns_mac_rdy,
    output logic [TOTAL_CHNL_NUM-1:0]        ns_adapter_rstn,
    output logic [TOTAL_CHNL_NUM-1:0]        sl_rx_dcc_dll_lock_req,
    output logic [TOTAL_CHNL_NUM-1:0]        sl_tx_dcc_dll_lock_req,
    output logic [16:0]                      avmm_address_o,
    output logic                             avmm_write_o,
    output logic                             avmm_read_o,
    output logic [31:0]                      avmm_writedata_o,
    output logic [3:0]                       avmm_byteenable_o,
    input  logic                             avmm_waitrequest_i
);

    localparam int unsigned CNT_MAX = (RST_HOLD_CYC > TIMEOUT_CYC) ? RST_HOLD_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               cfg_ok_q, cfg_ok_d;
    logic               pend_q, pend_d;
    logic               rdy_q, rdy_d;
    logic               lock_q, lock_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic               cnt_clr;
    logic               wr_start, wr_abort, wr_done, wr_busy;
    logic               wr_pending, restart_req, all_en;

    assign wr_pending  = wr_busy && avmm_waitrequest_i;
    assign restart_req = calib_restart || pend_q;
    assign all_en      = (&ms_tx_transfer_en) && (&ms_rx_transfer_en);

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        retry_d  = retry_q;
        cfg_ok_d = cfg_ok_q;
        pend_d   = pend_q;
        wr_start = 1'b0;
        wr_abort = 1'b0;
        // a restart arriving under a stalled write waits for that word to be accepted
        if (restart_req && wr_pending) begin
            pend_d = 1'b1;
        end else if (restart_req) begin
            state_d  = ST_RESET_HOLD;
            cnt_clr  = 1'b1;
            retry_d  = '0;
            cfg_ok_d = 1'b0;
            pend_d   = 1'b0;
            wr_abort = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET_HOLD;
                    cnt_clr = 1'b1;
                end
                ST_RESET_HOLD: begin
                    if (cnt_q == CNT_W'(RST_HOLD_CYC - 1)) begin
                        if (cfg_ok_q) begin
                            state_d = ST_ASSERT_READY;
                        end else begin
                            state_d  = ST_CFG_WRITE;
                            wr_start = 1'b1;
                        end
                    end
                end
                ST_CFG_WRITE: begin
                    if (wr_done) begin
                        state_d  = ST_CFG_DONE;
                        cfg_ok_d = 1'b1;
                    end
                end
                ST_CFG_DONE:          state_d = ST_ASSERT_READY;
                ST_ASSERT_READY:      state_d = ST_SEND_DLL_LOCK_REQ;
                ST_SEND_DLL_LOCK_REQ: begin
                    state_d = ST_WAIT_TRANSFER_EN;
                    cnt_clr = 1'b1;
                end
                ST_WAIT_TRANSFER_EN: begin
                    if (all_en) begin
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ST_RESET_HOLD;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_DONE: begin
                    if (!all_en) begin
                        state_d = ST_RESET_HOLD;
                        retry_d = '0;
                        cnt_clr = 1'b1;
                    end
                end
                ST_FAIL:  state_d = ST_FAIL;
                default:  state_d = ST_IDLE;
            endcase
        end

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (state_q == ST_RESET_HOLD || state_q == ST_WAIT_TRANSFER_EN) begin
            cnt_d = cnt_q + 1'b1;
        end

        rdy_d  = state_d inside {ST_ASSERT_READY, ST_SEND_DLL_LOCK_REQ, ST_WAIT_TRANSFER_EN, ST_DONE};
        lock_d = state_d inside {ST_SEND_DLL_LOCK_REQ, ST_WAIT_TRANSFER_EN, ST_DONE};
        done_d = (state_d == ST_DONE);
        fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            cfg_ok_q <= 1'b0;
            pend_q   <= 1'b0;
            rdy_q    <= 1'b0;
            lock_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            cfg_ok_q <= cfg_ok_d;
            pend_q   <= pend_d;
            rdy_q    <= rdy_d;
            lock_q   <= lock_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    aib_avmm_cfg_writer #(
        .NUM_WORDS (NUM_CFG_WORDS)
    ) u_cfg_writer (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (wr_start),
        .abort_i            (wr_abort),
        .done_o             (wr_done),
        .busy_o             (wr_busy),
        .avmm_address_o     (avmm_address_o),
        .avmm_write_o       (avmm_write_o),
        .avmm_writedata_o   (avmm_writedata_o),
        .avmm_byteenable_o  (avmm_byteenable_o),
        .avmm_waitrequest_i (avmm_waitrequest_i)
    );

    assign avmm_read_o            = 1'b0;
    assign calib_done             = done_q;
    assign calib_fail             = fail_q;
    assign retry_count            = retry_q;
    assign i_conf_done            = cfg_ok_q;
    assign ns_mac_rdy             = {TOTAL_CHNL_NUM{rdy_q}};
    assign ns_adapter_rstn        = {TOTAL_CHNL_NUM{rdy_q}};
    assign sl_rx_dcc_dll_lock_req = {TOTAL_CHNL_NUM{lock_q}};
    assign sl_tx_dcc_dll_lock_req = {TOTAL_CHNL_NUM{lock_q}};

endmodule

// File: tb/tb_aib_calib_slave_fsm.sv
// Timeline-driven bench: each calibration phase is a run of cycles with known duration
// and expected pins; random stimulus fills every input the current phase must ignore.
module tb_aib_calib_slave_fsm;
    import aib_calib_pkg::*;

    localparam int unsigned NCH  = 24;
    localparam int unsigned HOLD = 16;
    localparam int unsigned TMO  = 4096;
    localparam int unsigned MAXR = 3;
    localparam int unsigned NW   = 4;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           calib_restart;
    logic [NCH-1:0]                 ms_tx_transfer_en;
    logic [NCH-1:0]                 ms_rx_transfer_en;
    logic                           calib_done;
    logic                           calib_fail;
    logic [$clog2(MAXR+1)-1:0]      retry_count;
    logic                           i_conf_done;
    logic [NCH-1:0]                 ns_mac_rdy;
    logic [NCH-1:0]                 ns_adapter_rstn;
    logic [NCH-1:0]                 sl_rx_dcc_dll_lock_req;
    logic [NCH-1:0]                 sl_tx_dcc_dll_lock_req;
    logic [16:0]                    avmm_address_o;
    logic                           avmm_write_o;
    logic                           avmm_read_o;
    logic [31:0]                    avmm_writedata_o;
    logic [3:0]                     avmm_byteenable_o;
    logic                           avmm_waitrequest_i;

    always #5 clk = ~clk;

    aib_calib_slave_fsm #(
        .TOTAL_CHNL_NUM (NCH),
        .RST_HOLD_CYC   (HOLD),
        .TIMEOUT_CYC    (TMO),
        .MAX_RETRY      (MAXR),
        .NUM_CFG_WORDS  (NW)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .calib_restart          (calib_restart),
        .ms_tx_transfer_en      (ms_tx_transfer_en),
        .ms_rx_transfer_en      (ms_rx_transfer_en),
        .calib_done             (calib_done),
        .calib_fail             (calib_fail),
        .retry_count            (retry_count),
        .i_conf_done            (i_conf_done),
        .ns_mac_rdy             (ns_mac_rdy),
        .ns_adapter_rstn        (ns_adapter_rstn),
        .sl_rx_dcc_dll_lock_req (sl_rx_dcc_dll_lock_req),
        .sl_tx_dcc_dll_lock_req (sl_tx_dcc_dll_lock_req),
        .avmm_address_o         (avmm_address_o),
        .avmm_write_o           (avmm_write_o),
        .avmm_read_o            (avmm_read_o),
        .avmm_writedata_o       (avmm_writedata_o),
        .avmm_byteenable_o      (avmm_byteenable_o),
        .avmm_waitrequest_i     (avmm_waitrequest_i)
    );

    typedef struct {
        bit             rstn;
        bit             rdy;
        bit             lock;
        bit             done;
        bit             fail;
        bit             wr;
        logic [16:0]    addr;
        logic [31:0]    data;
        bit             wreq;
        bit             restart;
        logic [NCH-1:0] tx;
        logic [NCH-1:0] rx;
    } cyc_t;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned cyc;
    bit          ended;
    bit          m_conf;
    int unsigned m_retry;
    int unsigned stall [NW];

    task automatic finish_run();
        if (!ended) begin
            ended = 1'b1;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic cyc_t phase(input string ph);
        cyc_t e;
        e.rstn    = (ph == "ready") || (ph == "lock") || (ph == "wait") || (ph == "done");
        e.rdy     = e.rstn;
        e.lock    = (ph == "lock") || (ph == "wait") || (ph == "done");
        e.done    = (ph == "done");
        e.fail    = (ph == "fail");
        e.wr      = 1'b0;
        e.addr    = '0;
        e.data    = '0;
        e.wreq    = 1'($urandom_range(0, 1));
        e.restart = 1'b0;
        e.tx      = NCH'($urandom);
        e.rx      = NCH'($urandom);
        return e;
    endfunction

    task automatic step(input cyc_t e);
        @(posedge clk);
        #1;
        calib_restart      = e.restart;
        avmm_waitrequest_i = e.wreq;
        ms_tx_transfer_en  = e.tx;
        ms_rx_transfer_en  = e.rx;
        @(negedge clk);
        cyc++;
        check_eq("ns_adapter_rstn", 64'(ns_adapter_rstn), 64'({NCH{e.rstn}}));
        check_eq("ns_mac_rdy", 64'(ns_mac_rdy), 64'({NCH{e.rdy}}));
        check_eq("sl_rx_lock_req", 64'(sl_rx_dcc_dll_lock_req), 64'({NCH{e.lock}}));
        check_eq("sl_tx_lock_req", 64'(sl_tx_dcc_dll_lock_req), 64'({NCH{e.lock}}));
        check_eq("calib_done", 64'(calib_done), 64'(e.done));
        check_eq("calib_fail", 64'(calib_fail), 64'(e.fail));
        check_eq("i_conf_done", 64'(i_conf_done), 64'(m_conf));
        check_eq("retry_count", 64'(retry_count), 64'(m_retry));
        check_eq("avmm_write", 64'(avmm_write_o), 64'(e.wr));
        check_eq("avmm_read", 64'(avmm_read_o), 64'(0));
        check_eq("avmm_byteenable", 64'(avmm_byteenable_o), e.wr ? 64'hF : 64'h0);
        if (e.wr) begin
            check_eq("avmm_address", 64'(avmm_address_o), 64'(e.addr));
            check_eq("avmm_writedata", 64'(avmm_writedata_o), 64'(e.data));
        end
        if (n_bad >= 40) finish_run();
    endtask

    task automatic do_hold();
        repeat (HOLD) step(phase("hold"));
    endtask

    task automatic do_writes(input int unsigned st [NW], input int rs_word, output bit restarted);
        cyc_t e;
        int   rs_at;
        restarted = 1'b0;
        for (int w = 0; w < int'(NW); w++) begin
            rs_at = -1;
            if (w == rs_word) rs_at = int'($urandom_range(0, st[w] - 1));
            for (int s = 0; s <= int'(st[w]); s++) begin
                e         = phase("write");
                e.wr      = 1'b1;
                e.addr    = CFG_ADDR[w];
                e.data    = CFG_DATA[w];
                e.wreq    = (s < int'(st[w]));
                e.restart = (s == rs_at);
                step(e);
            end
            if (w == rs_word) begin
                restarted = 1'b1;
                m_conf    = 1'b0;
                m_retry   = 0;
                return;
            end
        end
    endtask

    task automatic bring_up(input int unsigned st [NW], input int rs_word);
        bit r;
        forever begin
            do_hold();
            if (m_conf) break;
            do_writes(st, rs_word, r);
            rs_word = -1;
            if (!r) begin
                m_conf = 1'b1;
                step(phase("cfgdone"));
                break;
            end
        end
        step(phase("ready"));
        step(phase("lock"));
    endtask

    task automatic do_wait(input int unsigned n, input bit all_at_end, input bit partial_rx);
        cyc_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e = phase("wait");
            if (all_at_end && i == n - 1) begin
                e.tx = '1;
                e.rx = '1;
            end else if (partial_rx) begin
                e.tx = '1;
                e.rx = '1;
                e.rx[$urandom_range(0, NCH-1)] = 1'b0;
            end else if ((&e.tx) && (&e.rx)) begin
                e.tx[$urandom_range(0, NCH-1)] = 1'b0;
            end
            step(e);
        end
    endtask

    task automatic do_done(input int unsigned n, input bit restart_end, input int drop_tx_bit);
        cyc_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e    = phase("done");
            e.tx = '1;
            e.rx = '1;
            if (i == n - 1) begin
                if (restart_end) e.restart = 1'b1;
                else if (drop_tx_bit >= 0) e.tx[drop_tx_bit] = 1'b0;
                else e.rx[$urandom_range(0, NCH-1)] = 1'b0;
            end
            step(e);
        end
        if (restart_end) m_conf = 1'b0;
        m_retry = 0;
    endtask

    task automatic do_fail(input int unsigned n);
        cyc_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e = phase("fail");
            e.restart = (i == n - 1);
            step(e);
        end
        m_conf  = 1'b0;
        m_retry = 0;
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; ended = 1'b0;
        m_conf = 1'b0; m_retry = 0;
        rst_n = 1'b0; calib_restart = 1'b0; avmm_waitrequest_i = 1'b0;
        ms_tx_transfer_en = '0; ms_rx_transfer_en = '0;
        repeat (3) @(posedge clk);
        ms_tx_transfer_en = '1; ms_rx_transfer_en = '1;
        @(negedge clk);
        check_eq("rst_adapter_rstn", 64'(ns_adapter_rstn), 64'(0));
        check_eq("rst_mac_rdy", 64'(ns_mac_rdy), 64'(0));
        check_eq("rst_lock_req", 64'({sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req}), 64'(0));
        check_eq("rst_done_fail_conf", 64'({calib_done, calib_fail, i_conf_done}), 64'(0));
        check_eq("rst_retry_count", 64'(retry_count), 64'(0));
        check_eq("rst_avmm_write", 64'({avmm_write_o, avmm_read_o, avmm_byteenable_o}), 64'(0));
        rst_n = 1'b1;

        // nominal bring-up: writes on cycles 17-20, enables all-ones at 30, then link drop on tx[5]
        stall = '{0, 0, 0, 0};
        bring_up(stall, -1);
        do_wait(7, 1'b1, 1'b0);
        do_done($urandom_range(3, 12), 1'b0, 5);

        // recovery without CSR rewrite, random drop on rx
        bring_up(stall, -1);
        do_wait($urandom_range(1, 60), 1'b1, 1'b0);
        do_done($urandom_range(2, 8), 1'b0, -1);

        // partial rx enable runs into one timeout
        bring_up(stall, -1);
        do_wait(TMO, 1'b0, 1'b1);
        m_retry++;
        bring_up(stall, -1);
        do_wait($urandom_range(1, 40), 1'b1, 1'b0);
        do_done($urandom_range(2, 8), 1'b1, -1);

        // stalled word 1 on the rewrite after restart
        stall = '{$urandom_range(0, 2), 3, $urandom_range(0, 2), $urandom_range(0, 2)};
        bring_up(stall, -1);

        // enables never arrive: three retries then failure
        for (int t = 0; t < 4; t++) begin
            do_wait(TMO, 1'b0, 1'b0);
            if (m_retry < MAXR) begin
                m_retry++;
                bring_up(stall, -1);
            end
        end
        do_fail($urandom_range(3, 10));

        // restart during a stalled word 2, table rewritten from word 0
        stall = '{$urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(3, 5), $urandom_range(0, 2)};
        bring_up(stall, 2);
        do_wait($urandom_range(1, 40), 1'b1, 1'b0);
        do_done($urandom_range(2, 8), 1'b0, -1);
        bring_up(stall, -1);
        do_wait($urandom_range(1, 20), 1'b1, 1'b0);
        do_done(4, 1'b1, -1);

        finish_run();
    end

endmodule

// File: doc/aib_calib_slave_fsm.md
Name: aib_calib_slave_fsm

Overview:
Slave-side (far-end) counterpart of the AIB master calibration FSM.
- Holds the slave adapter in reset, then programs its CSRs with a fixed table of Avalon-MM writes.
- Raises ns_mac_rdy, ns_adapter_rstn and the slave DCC/DLL lock requests.
- Waits for the master's ms_tx/ms_rx transfer enables on all channels.
- Adds timeout/retry and link-drop recovery.

Parameters:
TOTAL_CHNL_NUM, 24, number of AIB channels
RST_HOLD_CYC, 16, cycles ns_adapter_rstn is held low in RESET_HOLD (>=1)
TIMEOUT_CYC, 4096, cycles allowed in WAIT_TRANSFER_EN before a retry (>=1)
MAX_RETRY, 3, retries permitted before declaring failure
NUM_CFG_WORDS, 4, entries in the package config table (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
calib_restart  in  1  one-cycle pulse; restarts calibration from RESET_HOLD
ms_tx_transfer_en  in  TOTAL_CHNL_NUM  master TX transfer enable, already synchronised to clk
ms_rx_transfer_en  in  TOTAL_CHNL_NUM  master RX transfer enable, already synchronised to clk
calib_done  out  1  calibration complete
calib_fail  out  1  retries exhausted; sticky until reset or restart
retry_count  out  $clog2(MAX_RETRY+1)  timeouts taken in the current attempt
i_conf_done  out  1  CSR configuration complete
ns_mac_rdy  out  TOTAL_CHNL_NUM  MAC ready, all bits driven identically
ns_adapter_rstn  out  TOTAL_CHNL_NUM  adapter reset release, all bits driven identically
sl_rx_dcc_dll_lock_req  out  TOTAL_CHNL_NUM  RX DCC/DLL lock request
sl_tx_dcc_dll_lock_req  out  TOTAL_CHNL_NUM  TX DCC/DLL lock request
avmm_address_o  out  17  Avalon write address
avmm_write_o  out  1  Avalon write strobe
avmm_read_o  out  1  tied 0
avmm_writedata_o  out  32  Avalon write data
avmm_byteenable_o  out  4  constant 4'hF when writing, else 0
avmm_waitrequest_i  in  1  slave stall

Behaviour:
- Reset: the asynchronous active-low reset puts the FSM in IDLE. All outputs are 0 and all counters are 0.
- Output timing: outputs are flops loaded from next-state decode. Each state's values are visible in the cycle the FSM occupies that state.
- States and transitions:
  - IDLE: 1 cycle, then RESET_HOLD.
  - RESET_HOLD: ns_adapter_rstn=0, ns_mac_rdy=0, lock_req=0, calib_done=0.
    - Lasts RST_HOLD_CYC cycles.
    - Then goes to CFG_WRITE if cfg_ok=0, else to ASSERT_READY.
  - CFG_WRITE: issues table word i (i=0..NUM_CFG_WORDS-1).
    - avmm_write_o=1 with address and data stable while avmm_waitrequest_i=1.
    - A word is accepted on a cycle with write=1 and waitrequest=0; word i+1 is presented the next cycle (back-to-back).
    - After the last word is accepted, go to CFG_DONE with avmm_write_o=0.
  - CFG_DONE: 1 cycle. Sets cfg_ok=1; i_conf_done=1 from here until reset or restart.
  - ASSERT_READY: 1 cycle. ns_mac_rdy and ns_adapter_rstn become all-ones.
  - SEND_DLL_LOCK_REQ: 1 cycle. Both lock_req become all-ones. The timeout counter is cleared.
  - WAIT_TRANSFER_EN:
    - If ms_tx_transfer_en and ms_rx_transfer_en are both all-ones, go to DONE.
    - Else, if the counter reaches TIMEOUT_CYC-1: when retry_count<MAX_RETRY, increment retry_count and go to RESET_HOLD; otherwise go to FAIL.
  - DONE: calib_done=1; ready, rstn and lock_req stay asserted.
    - If any transfer_en bit drops, go to RESET_HOLD with retry_count cleared.
    - calib_done is low in the first RESET_HOLD cycle.
  - FAIL: calib_fail=1, all channel outputs 0. Left only by reset or calib_restart.
- Restart:
  - calib_restart clears cfg_ok, retry_count and calib_fail, then enters RESET_HOLD.
  - If a write is pending (write=1, waitrequest=1), the restart is latched and taken the cycle after that word is accepted. A pending write is never withdrawn.
- Retries after a timeout do not rewrite the CSRs (cfg_ok=1).
- Partial enables (any bit 0 on either vector) never satisfy the WAIT_TRANSFER_EN exit condition.

Decomposition:
- Package aib_calib_pkg holds:
  - state_t enum;
  - the CFG_ADDR[NUM_CFG_WORDS] (17b) and CFG_DATA[NUM_CFG_WORDS] (32b) constant arrays;
  - the AVMM_WIDTH=32, BYTE_WIDTH=4 and ADDR_WIDTH=17 constants.
- One sub-module: aib_avmm_cfg_writer (start/done handshake, table walk, waitrequest handling). The FSM instantiates it.

Test Plan:
1. Nominal path (default parameters, waitrequest=0):
   - Stimulus: both enables all-ones at cycle 30 after reset release.
   - Response: 4 writes on cycles 17-20; i_conf_done rises at cycle 21; lock_req rises at cycle 23; WAIT_TRANSFER_EN entered at cycle 24; calib_done=1 at cycle 31.
2. Write stall: waitrequest=1 for 3 cycles on word 1 -> address/data for word 1 held stable for 4 cycles; exactly 4 accepted writes; avmm_read_o=0 throughout.
3. Retry then fail: enables never asserted.
   - Timeouts 1-3: retry_count steps 1,2,3; ns_adapter_rstn is low for 16 cycles each time; no further Avalon writes.
   - Timeout 4: calib_fail=1 and all channel outputs 0.
4. Partial enable: 23 of 24 bits set on ms_rx_transfer_en -> no DONE; timeout fires after 4096 cycles; retry_count=1.
5. Restart mid-write: calib_restart during a stalled word 2 -> word 2 completes, then RESET_HOLD; the full table of 4 words is rewritten from word 0; i_conf_done is low until the new CFG_DONE.
6. Link drop: in DONE, clear bit 5 of ms_tx_transfer_en -> calib_done=0 on the next cycle; retry_count=0; ns_adapter_rstn low for 16 cycles; re-enters WAIT_TRANSFER_EN without any Avalon writes.
